// File: rtl/reg16_en.sv
// Load-enabled data register for LC-3 datapath state (PC, IR, MAR, MDR).
// Asynchronous active-low reset forces RESET_VALUE; otherwise loads D on enabled rising edges.
module reg16_en #(
    parameter int unsigned    WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    input  logic             en,
    output logic [WIDTH-1:0] Q
);

    // Q comes straight from the flops; D and en only reach it through the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            Q <= RESET_VALUE;
        else if (en)
            Q <= D;
    end

endmodule

// File: tb/tb_reg16_en.sv
// Directed bench for reg16_en: vector table for load/hold/boundary data plus
// hand-written sequences for async reset, release at an edge and RESET_VALUE override.
module tb_reg16_en;

    logic        clk;
    logic        reset;
    logic [15:0] d;
    logic        en;
    logic [15:0] q;

    logic        reset_b;
    logic [15:0] d_b;
    logic        en_b;
    logic [15:0] q_b;

    int tests_run = 0;
    int tests_failed = 0;

    reg16_en u_dut (
        .clk   (clk),
        .reset (reset),
        .D     (d),
        .en    (en),
        .Q     (q)
    );

    reg16_en #(.WIDTH(16), .RESET_VALUE(16'h3000)) u_dut_rv (
        .clk   (clk),
        .reset (reset_b),
        .D     (d_b),
        .en    (en_b),
        .Q     (q_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [15:0] d;
        logic [15:0] exp_q;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs [11];
        logic [15:0] prev_q;

        vecs[0]  = '{1'b1, 16'h3000, 16'h3000};
        vecs[1]  = '{1'b1, 16'h3001, 16'h3001};
        vecs[2]  = '{1'b0, 16'hFFFF, 16'h3001};
        vecs[3]  = '{1'b0, 16'h0000, 16'h3001};
        vecs[4]  = '{1'b0, 16'hFFFF, 16'h3001};
        vecs[5]  = '{1'b0, 16'h0000, 16'h3001};
        vecs[6]  = '{1'b0, 16'hFFFF, 16'h3001};
        vecs[7]  = '{1'b1, 16'hFFFF, 16'hFFFF};
        vecs[8]  = '{1'b1, 16'h0000, 16'h0000};
        vecs[9]  = '{1'b1, 16'h8000, 16'h8000};
        vecs[10] = '{1'b1, 16'h0001, 16'h0001};

        reset   = 1'b0;
        en      = 1'b0;
        d       = 16'h0000;
        reset_b = 1'b1;
        en_b    = 1'b0;
        d_b     = 16'h0000;

        // Reset state after a couple of edges under reset.
        repeat (2) @(negedge clk);
        check("reset_state", q, 16'h0000);

        // Mid-cycle release; the very next edge loads.
        reset = 1'b1;
        en    = 1'b1;
        d     = 16'hBEEF;
        #1 check("release_no_edge", q, 16'h0000);
        @(negedge clk);
        check("first_load_beef", q, 16'hBEEF);

        // Async assertion with no clock edge in between.
        #2 reset = 1'b0;
        #1 check("async_reset", q, 16'h0000);
        d  = 16'h1234;
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_held", q, 16'h0000);
        end

        // Release right at a rising edge: that edge must not load.
        d = 16'hA5A5;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("release_edge_noload", q, 16'h0000);
        @(negedge clk);
        check("release_next_load", q, 16'hA5A5);

        // Table: load, hold with toggling D, boundary patterns.
        prev_q = 16'hA5A5;
        for (int i = 0; i < 11; i++) begin
            en = vecs[i].en;
            d  = vecs[i].d;
            #1 check("pre_edge_unchanged", q, prev_q);
            @(negedge clk);
            check("vec_after_edge", q, vecs[i].exp_q);
            prev_q = vecs[i].exp_q;
        end

        // Reset overrides a load pending on the coming edge.
        en = 1'b1;
        d  = 16'h5A5A;
        #2 reset = 1'b0;
        @(negedge clk);
        check("reset_over_load", q, 16'h0000);
        reset = 1'b1;

        // RESET_VALUE override.
        reset_b = 1'b0;
        #1 check("rv_reset", q_b, 16'h3000);
        en_b = 1'b1;
        d_b  = 16'h3005;
        @(negedge clk);
        check("rv_reset_held", q_b, 16'h3000);
        reset_b = 1'b1;
        @(negedge clk);
        check("rv_load", q_b, 16'h3005);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
